saxil_read_regbank: RTL

Parametrised AXI4-Lite slave read channel that serves reads from an internal register bank. It is the successor to the fixed single-transaction read top and adds configurable data width, register count and response-queue depth, plus multiple outstanding reads, range and security checking with SLVERR, and a local write port that loads the bank. It sits between an AXI4-Lite interconnect master and the block's control/status logic.

---
 rtl/saxil_pkg.sv | 19 +
 rtl/saxil_read_regbank_if.sv | 24 ++
 rtl/saxil_resp_fifo.sv | 68 ++++++
 rtl/saxil_read_regbank.sv | 101 ++++++++++
 4 files changed

// File: rtl/saxil_pkg.sv
// Shared response codes and sizing helper for the AXI4-Lite register-bank read slave.
package saxil_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/saxil_read_regbank_if.sv
// AXI4-Lite read address and read data channels between interconnect master and slave.
interface saxil_read_regbank_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  saxil_read_arvalid;
  logic                  saxil_read_arready;
  logic [ADDR_WIDTH-1:0] saxil_read_araddr;
  logic [2:0]            saxil_read_arprot;
  logic                  saxil_read_rvalid;
  logic                  saxil_read_rready;
  logic [DATA_WIDTH-1:0] saxil_read_rdata;
  logic [1:0]            saxil_read_rresp;

  modport master (
    output saxil_read_arvalid, saxil_read_araddr, saxil_read_arprot, saxil_read_rready,
    input  saxil_read_arready, saxil_read_rvalid, saxil_read_rdata, saxil_read_rresp
  );

  modport slave (
    input  saxil_read_arvalid, saxil_read_araddr, saxil_read_arprot, saxil_read_rready,
    output saxil_read_arready, saxil_read_rvalid, saxil_read_rdata, saxil_read_rresp
  );
endinterface

// File: rtl/saxil_resp_fifo.sv
// Synchronous response FIFO; reset clears pointers and count, storage is left as-is.
module saxil_resp_fifo
  import saxil_pkg::*;
#(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/saxil_read_regbank.sv
// AXI4-Lite read slave serving a local register bank with range/secure checks and queued responses.
module saxil_read_regbank
  import saxil_pkg::*;
#(
  parameter int                  ADDR_WIDTH  = 32,
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  NUM_REGS    = 16,
  parameter int                  RESP_DEPTH  = 4,
  parameter logic [NUM_REGS-1:0] SECURE_MASK = {NUM_REGS{1'b0}},
  localparam int                 IDX_W       = (NUM_REGS > 1) ? clog2(NUM_REGS) : 1
) (
  input  logic                  saxil_read_regbank_clk,
  input  logic                  saxil_read_regbank_rst,
  saxil_read_regbank_if.slave   s_axil,
  input  logic                  reg_wr_en,
  input  logic [IDX_W-1:0]      reg_wr_idx,
  input  logic [DATA_WIDTH-1:0] reg_wr_data
);

  localparam int ADDR_LSB = clog2(DATA_WIDTH / 8);
  localparam int CNT_W    = clog2(RESP_DEPTH) + 1;

  typedef struct packed {
    resp_t                 resp;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic                  rst;
  logic [DATA_WIDTH-1:0] bank_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] bank_d [NUM_REGS];
  logic [ADDR_WIDTH-1:0] word;
  logic [IDX_W-1:0]      rd_idx;
  logic                  in_range;
  logic                  secure_deny;
  logic                  ar_ready;
  logic                  r_valid;
  logic                  ar_hs;
  logic                  r_hs;
  entry_t                push_entry;
  entry_t                head_entry;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  unused_fifo_full;
  logic [1:0]            unused_prot;

  assign rst         = saxil_read_regbank_rst;
  assign unused_prot = {s_axil.saxil_read_arprot[2], s_axil.saxil_read_arprot[0]};

  // Decode: low address bits select bytes within a word and are ignored.
  assign word        = s_axil.saxil_read_araddr >> ADDR_LSB;
  assign rd_idx      = word[IDX_W-1:0];
  assign in_range    = (word < ADDR_WIDTH'(NUM_REGS));
  assign secure_deny = SECURE_MASK[rd_idx] && s_axil.saxil_read_arprot[1];

  always_comb begin
    push_entry.resp = RESP_OKAY;
    push_entry.data = '0;
    if (!in_range || secure_deny) push_entry.resp = RESP_SLVERR;
    else                          push_entry.data = bank_q[rd_idx];
  end

  // arready looks only at the current fill level, so a same-edge pop never frees a slot early.
  assign ar_ready = !rst && (fifo_count < CNT_W'(RESP_DEPTH));
  assign r_valid  = !rst && !fifo_empty;
  assign ar_hs    = s_axil.saxil_read_arvalid && ar_ready;
  assign r_hs     = r_valid && s_axil.saxil_read_rready;

  assign s_axil.saxil_read_arready = ar_ready;
  assign s_axil.saxil_read_rvalid  = r_valid;
  assign s_axil.saxil_read_rdata   = rst ? '0 : head_entry.data;
  assign s_axil.saxil_read_rresp   = rst ? RESP_OKAY : head_entry.resp;

  saxil_resp_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (saxil_read_regbank_clk),
    .rst       (rst),
    .push      (ar_hs),
    .push_data (push_entry),
    .pop       (r_hs),
    .head_data (head_entry),
    .full      (unused_fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Local writes land at the edge, so a same-edge read still sees the old bank value.
  always_comb begin
    bank_d = bank_q;
    if (reg_wr_en && ({1'b0, reg_wr_idx} < (IDX_W + 1)'(NUM_REGS))) begin
      bank_d[reg_wr_idx] = reg_wr_data;
    end
  end

  always_ff @(posedge saxil_read_regbank_clk) begin
    if (rst) bank_q <= '{default: '0};
    else     bank_q <= bank_d;
  end

endmodule
